// File: rtl/aes128_stream_sequencer.sv
// Stream sequencer for an iterative AES128 core: packs 32-bit words into key/plaintext, runs the
// core, then emits the 128-bit result as four words. Optional feature macro: AES_SEQ_KEY_REUSE_EN.
module aes128_stream_sequencer #(
  parameter int unsigned WATCHDOG = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_key_load,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         err,
  output logic         core_ce,
  output logic [127:0] core_data_in,
  output logic [127:0] core_key,
  input  logic [127:0] core_data_out,
  input  logic         core_done
);

  localparam int unsigned WdW = $clog2(WATCHDOG + 1);

  localparam logic [1:0] StLoad  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [2:0]     word_cnt_q, word_cnt_d;
  logic [1:0]     out_cnt_q, out_cnt_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   data_q, data_d;
  logic [127:0]   result_q, result_d;
  logic           started_q, started_d;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic           err_q, err_d;
  logic [2:0]     word_idx;
  logic [6:0]     word_base;
  logic [6:0]     out_base;

`ifndef AES_SEQ_KEY_REUSE_EN
  logic unused_key_load;
  assign unused_key_load = in_key_load;
`endif

  assign in_ready     = (state_q == StLoad);
  assign busy         = (state_q != StLoad);
  assign out_valid    = (state_q == StDrain);
  assign out_last     = out_valid && (out_cnt_q == 2'd3);
  assign out_base     = 7'd127 - {out_cnt_q, 5'd0};
  assign out_data     = result_q[out_base -: 32];
  assign err          = err_q;
  assign core_data_in = data_q;
  assign core_key     = key_q;

  always_comb begin
    state_d    = state_q;
    word_cnt_d = word_cnt_q;
    out_cnt_d  = out_cnt_q;
    key_d      = key_q;
    data_d     = data_q;
    result_d   = result_q;
    started_d  = started_q;
    wd_cnt_d   = wd_cnt_q;
    err_d      = err_q;
    core_ce    = 1'b0;
`ifdef AES_SEQ_KEY_REUSE_EN
    // A block opened without in_key_load skips straight to the data words.
    word_idx = (word_cnt_q == 3'd0 && !in_key_load) ? 3'd4 : word_cnt_q;
`else
    word_idx = word_cnt_q;
`endif
    word_base = 7'd127 - {word_idx[1:0], 5'd0};

    case (state_q)
      StLoad: begin
        if (in_valid) begin
          if (!word_idx[2]) key_d[word_base -: 32] = in_data;
          else              data_d[word_base -: 32] = in_data;
          word_cnt_d = word_idx + 3'd1;
          if (word_idx == 3'd7) begin
            state_d   = StRun;
            wd_cnt_d  = '0;
            started_d = 1'b0;
          end
        end
      end
      StRun: begin
        // Holding ce low while done is seen stops the core from restarting.
        core_ce = !(started_q && core_done);
        if (started_q && core_done) begin
          result_d  = core_data_out;
          started_d = 1'b0;
          out_cnt_d = 2'd0;
          state_d   = StDrain;
        end else begin
          if (!core_done) started_d = 1'b1;
          wd_cnt_d = wd_cnt_q + 1'b1;
          if (wd_cnt_d == WdW'(WATCHDOG)) begin
            err_d      = 1'b1;
            started_d  = 1'b0;
            word_cnt_d = 3'd0;
            state_d    = StLoad;
          end
        end
      end
      StDrain: begin
        if (out_ready) begin
          out_cnt_d = out_cnt_q + 2'd1;
          if (out_cnt_q == 2'd3) state_d = StLoad;
        end
      end
      default: state_d = StLoad;
    endcase

    if (reset) core_ce = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StLoad;
      word_cnt_q <= '0;
      out_cnt_q  <= '0;
      key_q      <= '0;
      data_q     <= '0;
      result_q   <= '0;
      started_q  <= 1'b0;
      wd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      word_cnt_q <= word_cnt_d;
      out_cnt_q  <= out_cnt_d;
      key_q      <= key_d;
      data_q     <= data_d;
      result_q   <= result_d;
      started_q  <= started_d;
      wd_cnt_q   <= wd_cnt_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_aes128_stream_sequencer.sv
// Scoreboard bench for aes128_stream_sequencer with a behavioural AES128 core stub.
module tb_aes128_stream_sequencer;
  localparam int unsigned WD = 64;
  localparam logic [127:0] C1Key = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1Pt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1Ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, in_key_load = 1'b0;
  logic [31:0] in_data = '0;
  logic out_valid, out_ready = 1'b0, out_last, busy, err, core_ce, core_done;
  logic [31:0] out_data;
  logic [127:0] core_data_in, core_key, core_data_out;

  int n_cmp = 0, n_err = 0;
  logic [31:0] exp_q[$];
  int pos = 0;
  bit blk_busy = 0, chk_rdy = 0, mon_en = 0, hold = 0, stuck = 0;
  int core_lat = 4;
  bit hold_pend = 0;
  logic [31:0] hold_data;
  logic hold_last;
  logic [127:0] model_key = '0;
  logic [7:0] sbox_t [256];

  always #5 clock = ~clock;

  aes128_stream_sequencer #(.WATCHDOG(WD)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_key_load(in_key_load), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .err(err), .core_ce(core_ce),
    .core_data_in(core_data_in), .core_key(core_key), .core_data_out(core_data_out),
    .core_done(core_done)
  );

  // ---------------- AES128 reference ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  initial for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));

  function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc, a0, a1, a2, a3;
    logic [7:0] s [16];
    logic [7:0] n [16];
    logic [127:0] st;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    st = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[st[127-8*i -: 8]];
      for (int rr = 0; rr < 4; rr++)
        for (int c = 0; c < 4; c++) n[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = n[4*c]; a1 = n[4*c+1]; a2 = n[4*c+2]; a3 = n[4*c+3];
          n[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          n[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          n[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          n[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int i = 0; i < 16; i++) st[127-8*i -: 8] = n[i];
      st = st ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return st;
  endfunction

  // ---------------- iterative core stub ----------------
  logic done_q = 1'b0;
  logic [127:0] dout_q = '0;
  int ccnt = 0;
  always @(posedge clock) begin
    if (reset) begin
      done_q <= 1'b0; ccnt <= 0; dout_q <= '0;
    end else if (core_ce) begin
      if (done_q) begin
        done_q <= 1'b0; ccnt <= 0;
      end else if (ccnt >= core_lat - 1) begin
        done_q <= 1'b1; dout_q <= aes_enc(core_key, core_data_in);
      end else ccnt <= ccnt + 1;
    end
  end
  assign core_done     = stuck ? 1'b1 : done_q;
  assign core_data_out = dout_q;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++; n_err++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    @(negedge clock);
    if (!reset && mon_en) begin
      if (hold_pend) begin
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_data", out_data, hold_data);
        chk("hold_last", out_last, hold_last);
      end
      hold_pend = 0;
      if (chk_rdy) chk("in_ready", in_ready, !blk_busy);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) fail("unexpected_out_word");
        else begin
          chk("out_data", out_data, exp_q.pop_front());
          chk("out_last", out_last, pos == 3);
          pos = (pos + 1) % 4;
          if (pos == 0) blk_busy = 0;
        end
      end else if (out_valid) begin
        hold_pend = 1; hold_data = out_data; hold_last = out_last;
      end
    end
  end

  initial forever begin
    @(posedge clock); #1;
    out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver ----------------
  task automatic send_word(input logic [31:0] d, input logic kl);
    int b;
    repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
    in_valid = 1'b1; in_data = d; in_key_load = kl; b = 0;
    while (!in_ready) begin
      @(posedge clock); #1; b++;
      if (b > 3000) begin fail("in_ready_timeout"); break; end
    end
    @(posedge clock); #1;
    in_valid = 1'b0; in_data = $urandom; in_key_load = 1'($urandom);
  endtask

  task automatic send_block(input logic [127:0] key, input logic [127:0] pt, input bit full,
                            input bit push, input logic [127:0] exp);
    logic kl0;
`ifdef AES_SEQ_KEY_REUSE_EN
    kl0 = full;
`else
    kl0 = 1'($urandom);
`endif
    if (push) for (int i = 0; i < 4; i++) exp_q.push_back(exp[127-32*i -: 32]);
    if (full) begin
      model_key = key;
      for (int i = 0; i < 4; i++) send_word(key[127-32*i -: 32], (i == 0) ? kl0 : 1'($urandom));
    end
    for (int i = 0; i < 4; i++)
      send_word(pt[127-32*i -: 32], (i == 0 && !full) ? 1'b0 : 1'($urandom));
    blk_busy = 1;
    chk("ce_after_last_word", core_ce, 1'b1);
    chk("busy_in_run", busy, 1'b1);
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while (exp_q.size() != 0 || blk_busy) begin
      @(posedge clock); b++;
      if (b > 3000) begin fail("drain_timeout"); break; end
    end
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    blk_busy = 0; pos = 0; hold_pend = 0; model_key = '0;
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] k, p;
    int n, b;
    bit saw_out;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_core_ce", core_ce, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    mon_en = 1; chk_rdy = 1;

    send_block(C1Key, C1Pt, 1, 1, C1Ct);
    wait_done();

    for (int i = 0; i < 6; i++) begin
      core_lat = $urandom_range(1, 20);
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(k, p, 1, 1, aes_enc(k, p));
      if (i % 2 == 1) wait_done();
    end
    wait_done();

    // out_ready held low for 10 cycles on the first result word
    hold = 1;
    send_block(C1Key, C1Pt, 1, 1, C1Ct);
    b = 0;
    while (!out_valid && b < 500) begin @(posedge clock); #1; b++; end
    if (!out_valid) fail("hold_valid_timeout");
    repeat (10) begin @(posedge clock); #1; end
    hold = 0;
    wait_done();

    // back-to-back blocks
    for (int i = 0; i < 2; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block(k, p, 1, 1, aes_enc(k, p));
    end
    wait_done();

    // watchdog abort with core_done stuck high
    chk_rdy = 0; stuck = 1; n = 0; b = 0; saw_out = 0;
    send_block(C1Key, C1Pt, 1, 0, '0);
    while (!err && b < 300) begin
      if (core_ce) n++;
      if (out_valid) saw_out = 1;
      @(posedge clock); #1; b++;
    end
    chk("wd_ce_cycles", n, WD);
    chk("wd_err", err, 1'b1);
    chk("wd_in_ready", in_ready, 1'b1);
    chk("wd_busy", busy, 1'b0);
    chk("wd_core_ce", core_ce, 1'b0);
    chk("wd_no_out", saw_out, 1'b0);
    repeat (5) begin @(posedge clock); #1; end
    chk("wd_err_sticky", err, 1'b1);
    stuck = 0;
    do_reset();
    chk("wd_err_cleared", err, 1'b0);

    // reset while RUN
    core_lat = 40;
    send_block(C1Key, C1Pt, 1, 0, '0);
    repeat (3) begin @(posedge clock); #1; end
    chk("run_core_ce", core_ce, 1'b1);
    reset = 1'b1;
    @(posedge clock); #1;
    chk("rstrun_core_ce", core_ce, 1'b0);
    chk("rstrun_out_valid", out_valid, 1'b0);
    chk("rstrun_in_ready", in_ready, 1'b1);
    chk("rstrun_err", err, 1'b0);
    reset = 1'b0;
    blk_busy = 0; pos = 0; model_key = '0; exp_q.delete();
    chk_rdy = 1;
    repeat (60) begin @(posedge clock); #1; end
    core_lat = 5;

`ifdef AES_SEQ_KEY_REUSE_EN
    send_block(C1Key, C1Pt, 1, 1, C1Ct);
    wait_done();
    send_block('0, C1Pt, 0, 1, C1Ct);
    wait_done();
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send_block(k, p, 1, 1, aes_enc(k, p));
    for (int i = 0; i < 2; i++) begin
      p = {$urandom, $urandom, $urandom, $urandom};
      send_block('0, p, 0, 1, aes_enc(model_key, p));
    end
    wait_done();
`else
    k = {$urandom, $urandom, $urandom, $urandom};
    p = {$urandom, $urandom, $urandom, $urandom};
    send_block(k, p, 1, 1, aes_enc(k, p));
    wait_done();
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    fail("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
